avr_serial_tx: RTL and testbench

FPGA-to-AVR serial transmitter for the Mojo board: accepts bytes from fabric logic through a valid/ready handshake, buffers them in a small FIFO, and serializes them as 8N1 UART frames on the `avr_rx` pin. It honours the AVR's `avr_rx_busy` flow-control line and only starts a frame while the AVR can accept one. It is the transmit-side counterpart of the AVR-to-FPGA receive path and replaces the high-Z tie-off on `avr_rx` in the top level.

---
 rtl/avr_serial_tx.sv | 198 +++++++++++++++++++
 tb/tb_avr_serial_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : avr_serial_tx
//  Description : FPGA-to-AVR 8N1 serial transmitter with a small byte FIFO.
//                Bytes enter through a valid/ready handshake and are
//                serialized LSB first on tx. A new frame starts only while
//                the synchronized AVR busy line (block) is low.
//  Ports       : clk      - system clock (sole clock)
//                rst_n    - synchronous active-low reset
//                data     - byte to send
//                new_data - data valid
//                ready    - FIFO can accept a byte
//                block    - AVR receive buffer full, asynchronous to clk
//                tx       - registered serial output to the AVR
//                busy     - frame in progress or FIFO non-empty
//                count    - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module avr_serial_tx #(
  parameter int CLK_RATE   = 50000000,
  parameter int BAUD       = 500000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data,
  input  logic                          new_data,
  output logic                          ready,
  input  logic                          block,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] c_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   c_FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_block_meta;
  logic            r_block_s;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_start_ok;
  logic            w_baud_last;
  logic [7:0]      w_head;

  // Acceptance looks only at the pre-edge occupancy, so a full FIFO refuses
  // a byte even when the FSM pops in the same cycle.
  assign w_push      = new_data && (r_count != c_FULL);
  assign w_start_ok  = (r_count != '0) && !r_block_s;
  assign w_baud_last = (r_baud == c_BAUD_LAST);
  // The start check is applied both from IDLE and on the last stop cycle,
  // which is what makes back-to-back frames contiguous.
  assign w_pop       = w_start_ok &&
                       ((r_state == S_IDLE) ||
                        ((r_state == S_STOP) && w_baud_last));
  assign w_head      = r_mem[r_rptr];

  assign ready = (r_count != c_FULL);
  assign busy  = (r_state != S_IDLE) || (r_count != '0);
  assign count = r_count;
  assign tx    = r_tx;

  // Two-flop synchronizer for the asynchronous AVR flow-control line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_block_meta <= 1'b0;
      r_block_s    <= 1'b0;
    end else begin
      r_block_meta <= block;
      r_block_s    <= r_block_meta;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmit FSM. tx is registered and is loaded with the level for the
  // next bit period at the same edge that enters that period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_start_ok) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_start_ok) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avr_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_avr_serial_tx
//  Description : Self-checking bench for avr_serial_tx. A frame-timeline
//                reference model (byte queue plus position inside the current
//                10-bit frame) predicts tx, ready, busy and count each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_serial_tx;

  localparam int C     = 100;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] data     = 8'h00;
  logic       new_data = 1'b0;
  logic       block    = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] count;

  avr_serial_tx #(
    .CLK_RATE   (50000000),
    .BAUD       (500000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .new_data (new_data),
    .ready    (ready),
    .block    (block),
    .tx       (tx),
    .busy     (busy),
    .count    (count)
  );

  always #10 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  int         m_cyc  = -1;   // position inside current frame, -1 when idle
  logic [7:0] m_cur  = 8'h00;
  logic       m_meta = 1'b0;
  logic       m_bs   = 1'b0;
  logic       m_acc  = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Line level at the current frame position: start, 8 data bits LSB first, stop.
  function automatic logic exp_tx();
    int k;
    if (m_cyc < 0) return 1'b1;
    k = m_cyc / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic tick();
    bit start_ok;
    bit can_start;
    @(posedge clk);
    m_acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_cyc  = -1;
      m_meta = 1'b0;
      m_bs   = 1'b0;
    end else begin
      start_ok  = (q.size() > 0) && !m_bs;
      can_start = (m_cyc < 0) || (m_cyc == FRAME - 1);
      m_acc     = new_data && (q.size() < DEPTH);
      if (can_start && start_ok) begin
        m_cur = q.pop_front();
        m_cyc = 0;
      end else if (m_cyc >= 0) begin
        m_cyc = m_cyc + 1;
        if (m_cyc == FRAME) m_cyc = -1;
      end
      if (m_acc) q.push_back(data);
      m_bs   = m_meta;
      m_meta = block;
    end
    #1;
    chk("tx",    32'(tx),    32'(exp_tx()));
    chk("ready", 32'(ready), 32'(q.size() != DEPTH));
    chk("busy",  32'(busy),  32'((m_cyc >= 0) || (q.size() != 0)));
    chk("count", 32'(count), 32'(q.size()));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    data     = b;
    new_data = 1'b1;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 20000);
    chk("send_accept", 32'(m_acc), 32'd1);
    new_data = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_cyc < 0 && q.size() == 0) && n < 30000) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(m_cyc < 0 && q.size() == 0), 32'd1);
  endtask

  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    while (m_cyc != t && n < 5000) begin
      tick();
      n++;
    end
    chk("reach_frame_pos", 32'(m_cyc), 32'(t));
  endtask

  initial begin
    logic [9:0] a5_bits;
    a5_bits = 10'b1101001010;   // bit k = expected level at mid-bit k

    // Reset
    run(2);
    rst_n = 1'b1;
    chk("rst_tx",    32'(tx),    32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    run(5);

    // Single byte 0xA5, mid-bit sampling
    send(8'hA5);
    tick();
    chk("a5_start_latency", 32'(tx), 32'd0);
    run(50);
    for (int k = 0; k < 10; k++) begin
      chk("a5_midbit", 32'(tx), 32'(a5_bits[k]));
      if (k < 9) run(100);
    end
    run(49);
    chk("a5_busy_last", 32'(busy), 32'd1);
    tick();
    chk("a5_busy_fall", 32'(busy), 32'd0);
    run(20);

    // Fill while blocked, 5th byte held, then back-to-back drain
    block = 1'b1;
    run(3);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(ready), 32'd0);
    data     = 8'h05;
    new_data = 1'b1;
    run(5);
    chk("held_count", 32'(count), 32'd4);
    chk("held_tx",    32'(tx),    32'd1);
    block = 1'b0;
    run(2);
    chk("rel_tx_wait", 32'(tx), 32'd1);
    tick();
    chk("rel_start",     32'(tx),    32'd0);
    chk("full_pop_nopush", 32'(count), 32'd3);
    tick();
    chk("fifth_accept", 32'(count), 32'd4);
    new_data = 1'b0;
    wait_idle();
    run(10);

    // Simultaneous push and pop with two bytes queued
    block = 1'b1;
    run(3);
    send(8'h3C);
    send(8'hC3);
    block = 1'b0;
    run(2);
    data     = 8'h99;
    new_data = 1'b1;
    tick();
    chk("pushpop_count", 32'(count), 32'd2);
    chk("pushpop_tx",    32'(tx),    32'd0);
    new_data = 1'b0;
    wait_idle();
    run(10);

    // Flow control hold and release latency
    block = 1'b1;
    run(3);
    send(8'h55);
    run(5000);
    chk("blk_tx",    32'(tx),    32'd1);
    chk("blk_count", 32'(count), 32'd1);
    block = 1'b0;
    run(2);
    chk("blk_rel_wait", 32'(tx), 32'd1);
    tick();
    chk("blk_rel_start", 32'(tx), 32'd0);
    wait_idle();
    run(10);

    // Block asserted mid-frame
    send(8'h0F);
    send(8'hF0);
    wait_cyc(299);
    block = 1'b1;
    wait_cyc(FRAME - 1);
    run(2000);
    chk("mid_blk_count", 32'(count), 32'd1);
    chk("mid_blk_tx",    32'(tx),    32'd1);
    chk("mid_blk_busy",  32'(busy),  32'd1);
    block = 1'b0;
    wait_idle();
    run(10);

    // Reset mid-frame with three bytes queued
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk("pre_rst_count", 32'(count), 32'd3);
    wait_cyc(449);
    rst_n = 1'b0;
    tick();
    chk("mrst_tx",    32'(tx),    32'd1);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_busy",  32'(busy),  32'd0);
    chk("mrst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    run(2500);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic with random block toggling
    for (int i = 0; i < 12; i++) begin
      run($urandom_range(0, 1200));
      if ($urandom_range(0, 3) == 0) block = ~block;
      if (block && q.size() >= 3) block = 1'b0;
      send(8'($urandom_range(0, 255)));
    end
    block = 1'b0;
    wait_idle();
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
